// File: rtl/cpu_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter_pkg
// Shared CPU-side definitions used by the CPU/DMA memory arbiter:
//   - cpu_rw_e     : CPU read/write select encoding (also used on rw0/rw1)
//   - arb_state_e  : arbiter FSM state encoding
//   - REQ_CPU/REQ_DMA : requester index constants
//   - WAIT_CYCLES_MAX : largest wait-state count the 4-bit counter can hold
//   - wait_load()  : clamps a wait-state parameter into the counter range
// -----------------------------------------------------------------------------
package cpu_mem_arbiter_pkg;

   typedef enum logic {
      CPU_RW_READ  = 1'b0,
      CPU_RW_WRITE = 1'b1
   } cpu_rw_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   localparam int WAIT_CYCLES_MAX = 15;

   // Out-of-range wait counts saturate so the counter never wraps.
   function automatic logic [3:0] wait_load(input int cycles);
      if (cycles > WAIT_CYCLES_MAX) begin
         wait_load = 4'(WAIT_CYCLES_MAX);
      end else if (cycles < 0) begin
         wait_load = 4'd0;
      end else begin
         wait_load = cycles[3:0];
      end
   endfunction

endpackage

// File: rtl/cpu_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// cpu_mem_arb_pick
// Combinational winner select between requester 0 (CPU) and requester 1 (DMA).
// A lone requester always wins. On a tie:
//   CPU_MEM_ARB_ROUND_ROBIN_EN defined   : the requester not granted last wins
//   CPU_MEM_ARB_ROUND_ROBIN_EN undefined : requester 0 always wins
// Ports:
//   req0, req1  in   pending requests
//   last_owner  in   index of the previous owner (round-robin build only)
//   winner      out  index of the selected requester
// -----------------------------------------------------------------------------
module cpu_mem_arb_pick
   import cpu_mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
   input  logic last_owner,
`endif
   output logic winner
);

   // Winner select; with no request the result is don't-care and reads as CPU.
   always_comb begin
      winner = REQ_CPU;
      if (req0 && req1) begin
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
         winner = ~last_owner;
`else
         winner = REQ_CPU;
`endif
      end else if (req1) begin
         winner = REQ_DMA;
      end else begin
         winner = REQ_CPU;
      end
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
// Two-requester (CPU=0, DMA=1) arbiter in front of a single memory port.
// Flow: IDLE -> ACCESS (WAIT_CYCLES+1 cycles, mem_en high) -> DONE (ack) -> IDLE.
// The winner's rw/addr/wdata are captured on the grant and held for the whole
// access, so requester inputs may change freely until the next IDLE.
// Optional feature: define CPU_MEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise requester 0 has fixed priority.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              gates new grants only; an access in flight completes
//   req0/req1           requests, held until the matching ack
//   rw0/rw1             read/write select (cpu_rw_e encoding)
//   addr0/addr1         requester addresses
//   wdata0/wdata1       requester write data
//   ack0/ack1           one-cycle completion pulse to the owner
//   rdata               read data, valid from the ack cycle until the next ack
//   busy                high in ACCESS and DONE
//   grant               index of the current/last owner
//   mem_en/mem_we       memory strobe and write enable
//   mem_addr/mem_wdata  memory address and write data
//   mem_rdata           memory read data, sampled in the last ACCESS cycle
// -----------------------------------------------------------------------------
module cpu_mem_arbiter
   import cpu_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  rw0,
   input  logic                  rw1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  grant,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

   arb_state_e            state_r,  state_nxt_s;
   logic [3:0]            cnt_r,    cnt_nxt_s;
   logic                  own_r,    own_nxt_s;
   cpu_rw_e               rw_r,     rw_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r,   addr_nxt_s;
   logic [DATA_WIDTH-1:0] wdata_r,  wdata_nxt_s;
   logic [DATA_WIDTH-1:0] rdata_r,  rdata_nxt_s;
   logic                  mem_en_r, mem_en_nxt_s;
   logic                  mem_we_r, mem_we_nxt_s;
   logic                  ack0_r,   ack0_nxt_s;
   logic                  ack1_r,   ack1_nxt_s;
   logic                  busy_r,   busy_nxt_s;
   logic                  win_s;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
   logic                  last_r,   last_nxt_s;
`endif

   cpu_mem_arb_pick u_pick (
      .req0       (req0),
      .req1       (req1),
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
      .last_owner (last_r),
`endif
      .winner     (win_s)
   );

   // State register plus all datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 4'd0;
         own_r    <= REQ_CPU;
         rw_r     <= CPU_RW_READ;
         addr_r   <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
         mem_en_r <= 1'b0;
         mem_we_r <= 1'b0;
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         busy_r   <= 1'b0;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
         // DMA as last owner lets the CPU win the first tie.
         last_r   <= REQ_DMA;
`endif
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         own_r    <= own_nxt_s;
         rw_r     <= rw_nxt_s;
         addr_r   <= addr_nxt_s;
         wdata_r  <= wdata_nxt_s;
         rdata_r  <= rdata_nxt_s;
         mem_en_r <= mem_en_nxt_s;
         mem_we_r <= mem_we_nxt_s;
         ack0_r   <= ack0_nxt_s;
         ack1_r   <= ack1_nxt_s;
         busy_r   <= busy_nxt_s;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
         last_r   <= last_nxt_s;
`endif
      end
   end

   // Next-state, wait counter, request capture and read-data capture.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      own_nxt_s   = own_r;
      rw_nxt_s    = rw_r;
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
      rdata_nxt_s = rdata_r;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
      last_nxt_s  = last_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (enable && (req0 || req1)) begin
               state_nxt_s = ST_ACCESS;
               cnt_nxt_s   = WAIT_LOAD;
               own_nxt_s   = win_s;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
               last_nxt_s  = win_s;
`endif
               if (win_s == REQ_DMA) begin
                  rw_nxt_s    = cpu_rw_e'(rw1);
                  addr_nxt_s  = addr1;
                  wdata_nxt_s = wdata1;
               end else begin
                  rw_nxt_s    = cpu_rw_e'(rw0);
                  addr_nxt_s  = addr0;
                  wdata_nxt_s = wdata0;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // Counter at zero marks the last ACCESS cycle, where mem_rdata is valid.
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_DONE;
               if (rw_r == CPU_RW_READ) begin
                  rdata_nxt_s = mem_rdata;
               end else begin
                  rdata_nxt_s = rdata_r;
               end
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the next state so they come straight from flops.
   always_comb begin
      mem_en_nxt_s = (state_nxt_s == ST_ACCESS);
      mem_we_nxt_s = (state_nxt_s == ST_ACCESS) && (rw_nxt_s == CPU_RW_WRITE);
      busy_nxt_s   = (state_nxt_s != ST_IDLE);
      ack0_nxt_s   = (state_nxt_s == ST_DONE) && (own_nxt_s == REQ_CPU);
      ack1_nxt_s   = (state_nxt_s == ST_DONE) && (own_nxt_s == REQ_DMA);
   end

   assign ack0      = ack0_r;
   assign ack1      = ack1_r;
   assign rdata     = rdata_r;
   assign busy      = busy_r;
   assign grant     = own_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;

endmodule
